// File: rtl/sys_ctrl_pkg.sv
// Shared definitions for the command-frame controller: opcodes, FSM states
// and the fixed register addresses used for ALU operands.
package sys_ctrl_pkg;

  localparam logic [7:0] OP_WR       = 8'hAA;
  localparam logic [7:0] OP_RD       = 8'hBB;
  localparam logic [7:0] OP_ALU      = 8'hCC;
  localparam logic [7:0] OP_ALU_NOP  = 8'hDD;
  localparam logic [7:0] OP_BURST_RD = 8'hEE;

  localparam int unsigned REG0 = 0;
  localparam int unsigned REG1 = 1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_ADDR,
    ST_WR_DATA,
    ST_RD_ADDR,
    ST_ALU_A,
    ST_ALU_B,
    ST_ALU_F,
    ST_BR_ADDR,
    ST_BR_CNT,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_TX_PUSH,
    ST_ALU_RUN,
    ST_ALU_WAIT,
    ST_ALU_PUSH
  } state_t;

  // States that are still gathering frame bytes from the RX side; only these
  // are subject to the inter-byte timeout.
  function automatic logic isCollecting(input state_t s);
    return (s == ST_WR_ADDR) || (s == ST_WR_DATA) || (s == ST_RD_ADDR) ||
           (s == ST_ALU_A)   || (s == ST_ALU_B)   || (s == ST_ALU_F)   ||
           (s == ST_BR_ADDR) || (s == ST_BR_CNT);
  endfunction

endpackage

// File: rtl/ctrl_timeout_cnt.sv
// Inter-byte timer. Counts cycles while enabled, restarts on every received
// byte, and saturates at TIMEOUT so the expiry flag stays up until cleared.
module ctrl_timeout_cnt #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [CW-1:0] cnt_q;

  // Count idle cycles inside a frame; leaving the frame or a new byte restarts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr_i || !en_i) begin
      cnt_q <= '0;
    end else if (cnt_q != CW'(TIMEOUT)) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign expired_o = en_i && (cnt_q == CW'(TIMEOUT));

endmodule

// File: rtl/sys_ctrl_burst.sv
// Command-frame controller: parses RX command frames, drives register-file
// reads/writes and the gated ALU, and streams responses into the TX FIFO.
// Supports burst register reads, multi-byte ALU results, an inter-byte
// timeout and frame-error reporting. All outputs come straight from flops.
module sys_ctrl_burst
  import sys_ctrl_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int ADDR_W    = 4,
  parameter int FUN_W     = 4,
  parameter int RES_BYTES = 2,
  parameter int TIMEOUT   = 255
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [WIDTH-1:0]           RX_P_DATA,
  input  logic                       RX_D_VLD,
  input  logic [WIDTH-1:0]           RD_DATA,
  input  logic                       RD_DATA_VALID,
  input  logic [RES_BYTES*WIDTH-1:0] ALU_OUT,
  input  logic                       ALU_OUT_VALID,
  input  logic                       FIFO_FULL,
  output logic [ADDR_W-1:0]          ADDRESS,
  output logic                       WR_EN,
  output logic                       RD_EN,
  output logic [WIDTH-1:0]           WR_DATA,
  output logic                       ALU_EN,
  output logic [FUN_W-1:0]           ALU_FUN,
  output logic                       CLK_EN,
  output logic [WIDTH-1:0]           TX_P_DATA,
  output logic                       TX_D_VLD,
  output logic                       FRAME_ERR
);

  localparam int RES_W = RES_BYTES * WIDTH;
  localparam int IDX_W = (RES_BYTES > 1) ? $clog2(RES_BYTES) : 1;

  state_t            state_q,     state_d;
  logic [ADDR_W-1:0] addr_q,      addr_d;
  logic [WIDTH-1:0]  cnt_q,       cnt_d;
  logic [RES_W-1:0]  result_q,    result_d;
  logic [IDX_W-1:0]  idx_q,       idx_d;
  logic [WIDTH-1:0]  byte_q,      byte_d;

  logic [ADDR_W-1:0] address_q,   address_d;
  logic              wr_en_q,     wr_en_d;
  logic              rd_en_q,     rd_en_d;
  logic [WIDTH-1:0]  wr_data_q,   wr_data_d;
  logic              alu_en_q,    alu_en_d;
  logic [FUN_W-1:0]  alu_fun_q,   alu_fun_d;
  logic              clk_en_q,    clk_en_d;
  logic [WIDTH-1:0]  tx_data_q,   tx_data_d;
  logic              tx_vld_q,    tx_vld_d;
  logic              frame_err_q, frame_err_d;

  logic collecting;
  logic toExpired;

  assign collecting = isCollecting(state_q);

  ctrl_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk       (CLK),
    .rst       (RST),
    .clr_i     (RX_D_VLD),
    .en_i      (collecting),
    .expired_o (toExpired)
  );

  // Next-state and next-output logic for the whole frame FSM. Strobes
  // default low every cycle; held outputs keep their value unless updated.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    idx_d       = idx_q;
    byte_d      = byte_q;
    address_d   = address_q;
    wr_data_d   = wr_data_q;
    alu_fun_d   = alu_fun_q;
    clk_en_d    = clk_en_q;
    tx_data_d   = tx_data_q;
    wr_en_d     = 1'b0;
    rd_en_d     = 1'b0;
    alu_en_d    = 1'b0;
    tx_vld_d    = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA == WIDTH'(OP_WR)) begin
            state_d = ST_WR_ADDR;
          end else if (RX_P_DATA == WIDTH'(OP_RD)) begin
            state_d = ST_RD_ADDR;
          end else if (RX_P_DATA == WIDTH'(OP_ALU)) begin
            state_d = ST_ALU_A;
          end else if (RX_P_DATA == WIDTH'(OP_ALU_NOP)) begin
            state_d = ST_ALU_F;
          end else if (RX_P_DATA == WIDTH'(OP_BURST_RD)) begin
            state_d = ST_BR_ADDR;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end

      ST_WR_ADDR: begin
        if (RX_D_VLD) begin
          addr_d  = RX_P_DATA[ADDR_W-1:0];
          state_d = ST_WR_DATA;
        end
      end

      ST_WR_DATA: begin
        if (RX_D_VLD) begin
          address_d = addr_q;
          wr_data_d = RX_P_DATA;
          wr_en_d   = 1'b1;
          state_d   = ST_IDLE;
        end
      end

      ST_RD_ADDR: begin
        if (RX_D_VLD) begin
          addr_d  = RX_P_DATA[ADDR_W-1:0];
          cnt_d   = WIDTH'(1);
          state_d = ST_RD_REQ;
        end
      end

      ST_ALU_A: begin
        if (RX_D_VLD) begin
          address_d = ADDR_W'(REG0);
          wr_data_d = RX_P_DATA;
          wr_en_d   = 1'b1;
          state_d   = ST_ALU_B;
        end
      end

      ST_ALU_B: begin
        if (RX_D_VLD) begin
          address_d = ADDR_W'(REG1);
          wr_data_d = RX_P_DATA;
          wr_en_d   = 1'b1;
          state_d   = ST_ALU_F;
        end
      end

      ST_ALU_F: begin
        if (RX_D_VLD) begin
          alu_fun_d = RX_P_DATA[FUN_W-1:0];
          clk_en_d  = 1'b1;
          state_d   = ST_ALU_RUN;
        end
      end

      ST_BR_ADDR: begin
        if (RX_D_VLD) begin
          addr_d  = RX_P_DATA[ADDR_W-1:0];
          state_d = ST_BR_CNT;
        end
      end

      ST_BR_CNT: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA == '0) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d   = RX_P_DATA;
            state_d = ST_RD_REQ;
          end
        end
      end

      ST_RD_REQ: begin
        address_d = addr_q;
        rd_en_d   = 1'b1;
        state_d   = ST_RD_WAIT;
      end

      ST_RD_WAIT: begin
        if (RD_DATA_VALID) begin
          byte_d  = RD_DATA;
          state_d = ST_TX_PUSH;
        end
      end

      ST_TX_PUSH: begin
        if (!FIFO_FULL) begin
          tx_data_d = byte_q;
          tx_vld_d  = 1'b1;
          if (cnt_q == WIDTH'(1)) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d   = cnt_q - WIDTH'(1);
            addr_d  = addr_q + ADDR_W'(1);
            state_d = ST_RD_REQ;
          end
        end
      end

      ST_ALU_RUN: begin
        alu_en_d = 1'b1;
        state_d  = ST_ALU_WAIT;
      end

      ST_ALU_WAIT: begin
        if (ALU_OUT_VALID) begin
          result_d = ALU_OUT;
          idx_d    = '0;
          clk_en_d = 1'b0;
          state_d  = ST_ALU_PUSH;
        end
      end

      ST_ALU_PUSH: begin
        if (!FIFO_FULL) begin
          tx_data_d = result_q[WIDTH-1:0];
          tx_vld_d  = 1'b1;
          result_d  = result_q >> WIDTH;
          if (idx_q == IDX_W'(RES_BYTES - 1)) begin
            state_d = ST_IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A stalled frame is abandoned; a byte arriving in the same cycle wins.
    if (collecting && !RX_D_VLD && toExpired) begin
      state_d     = ST_IDLE;
      frame_err_d = 1'b1;
    end
  end

  // State, datapath and output registers; reset abandons any frame or burst.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      idx_q       <= '0;
      byte_q      <= '0;
      address_q   <= '0;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      wr_data_q   <= '0;
      alu_en_q    <= 1'b0;
      alu_fun_q   <= '0;
      clk_en_q    <= 1'b0;
      tx_data_q   <= '0;
      tx_vld_q    <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      idx_q       <= idx_d;
      byte_q      <= byte_d;
      address_q   <= address_d;
      wr_en_q     <= wr_en_d;
      rd_en_q     <= rd_en_d;
      wr_data_q   <= wr_data_d;
      alu_en_q    <= alu_en_d;
      alu_fun_q   <= alu_fun_d;
      clk_en_q    <= clk_en_d;
      tx_data_q   <= tx_data_d;
      tx_vld_q    <= tx_vld_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign ADDRESS   = address_q;
  assign WR_EN     = wr_en_q;
  assign RD_EN     = rd_en_q;
  assign WR_DATA   = wr_data_q;
  assign ALU_EN    = alu_en_q;
  assign ALU_FUN   = alu_fun_q;
  assign CLK_EN    = clk_en_q;
  assign TX_P_DATA = tx_data_q;
  assign TX_D_VLD  = tx_vld_q;
  assign FRAME_ERR = frame_err_q;

endmodule

// File: tb/tb_sys_ctrl_burst.sv
// Bench for sys_ctrl_burst: emulates the register file, the gated ALU and a
// randomly stalling TX FIFO around the controller, and predicts every write,
// read, ALU start, TX byte and frame error from the frame contents alone.
module tb_sys_ctrl_burst;

  localparam int TO = 40;

  logic        CLK = 1'b0;
  logic        RST;
  logic [7:0]  RX_P_DATA;
  logic        RX_D_VLD;
  logic [7:0]  RD_DATA;
  logic        RD_DATA_VALID;
  logic [15:0] ALU_OUT;
  logic        ALU_OUT_VALID;
  logic        FIFO_FULL;
  logic [3:0]  ADDRESS;
  logic        WR_EN;
  logic        RD_EN;
  logic [7:0]  WR_DATA;
  logic        ALU_EN;
  logic [3:0]  ALU_FUN;
  logic        CLK_EN;
  logic [7:0]  TX_P_DATA;
  logic        TX_D_VLD;
  logic        FRAME_ERR;

  sys_ctrl_burst #(
    .WIDTH(8), .ADDR_W(4), .FUN_W(4), .RES_BYTES(2), .TIMEOUT(TO)
  ) dut (
    .CLK(CLK), .RST(RST),
    .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .RD_DATA(RD_DATA), .RD_DATA_VALID(RD_DATA_VALID),
    .ALU_OUT(ALU_OUT), .ALU_OUT_VALID(ALU_OUT_VALID),
    .FIFO_FULL(FIFO_FULL),
    .ADDRESS(ADDRESS), .WR_EN(WR_EN), .RD_EN(RD_EN), .WR_DATA(WR_DATA),
    .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN), .CLK_EN(CLK_EN),
    .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .FRAME_ERR(FRAME_ERR)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  logic [7:0]  rfMem  [16];
  logic [7:0]  refMem [16];
  logic [7:0]  frame [$];
  int wrQ[$],  rdQ[$],  aluQ[$],  txQ[$];
  int expWr[$], expRd[$], expAlu[$], expTx[$];
  int errCnt = 0;
  int expErr = 0;
  int rdDelay = 0;
  int aluDelay = 0;
  logic [3:0]  rdAddr;
  logic [15:0] aluRes;
  bit forceFull = 0;
  bit aluSlow = 0;
  bit fullSeen = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Behaviour of the emulated ALU, keyed by function code.
  function automatic logic [15:0] aluModel(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
    case (f)
      4'd0:    return 16'(a) + 16'(b);
      4'd1:    return 16'(a) - 16'(b);
      4'd2:    return 16'(a) * 16'(b);
      4'd3:    return {a, b};
      default: return {8'h00, a ^ b};
    endcase
  endfunction

  // FIFO_FULL as the controller saw it at the last rising edge.
  always @(posedge CLK) fullSeen <= FIFO_FULL;

  // Environment: register file, ALU, FIFO and event recorder, all at negedge.
  initial begin
    forever begin
      @(negedge CLK);
      RD_DATA_VALID = 1'b0;
      ALU_OUT_VALID = 1'b0;
      if (rdDelay > 0) begin
        rdDelay--;
        if (rdDelay == 0) begin
          RD_DATA = rfMem[rdAddr];
          RD_DATA_VALID = 1'b1;
        end
      end
      if (aluDelay > 0) begin
        if (!RST) checkOutput("clkEnHeld", {31'd0, CLK_EN}, 32'd1);
        aluDelay--;
        if (aluDelay == 0) begin
          ALU_OUT = aluRes;
          ALU_OUT_VALID = 1'b1;
        end
      end
      if (!RST) begin
        if (WR_EN) begin
          rfMem[ADDRESS] = WR_DATA;
          wrQ.push_back(int'({ADDRESS, WR_DATA}));
        end
        if (RD_EN) begin
          rdQ.push_back(int'(ADDRESS));
          rdAddr = ADDRESS;
          rdDelay = $urandom_range(1, 3);
        end
        if (ALU_EN) begin
          checkOutput("clkEnAtStart", {31'd0, CLK_EN}, 32'd1);
          aluQ.push_back(int'(ALU_FUN));
          aluRes = aluModel(rfMem[0], rfMem[1], ALU_FUN);
          aluDelay = aluSlow ? 30 : $urandom_range(1, 5);
        end
        if (TX_D_VLD) begin
          checkOutput("noPushWhenFull", {31'd0, fullSeen}, 32'd0);
          txQ.push_back(int'(TX_P_DATA));
        end
        if (FRAME_ERR) errCnt++;
      end
      FIFO_FULL = forceFull ? 1'b1 : ($urandom_range(0, 3) == 0);
    end
  end

  task automatic applyStimulus(input logic [7:0] b, input int gap);
    repeat (gap) @(negedge CLK);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    @(negedge CLK);
    RX_D_VLD  = 1'b0;
  endtask

  task automatic clearAll();
    wrQ.delete(); rdQ.delete(); aluQ.delete(); txQ.delete();
    expWr.delete(); expRd.delete(); expAlu.delete(); expTx.delete();
    errCnt = 0;
    expErr = 0;
  endtask

  // Predict the frame's effects from the command semantics and refMem.
  task automatic modelFrame();
    logic [7:0]  f [4];
    logic [3:0]  a;
    logic [15:0] r;
    for (int i = 0; i < 4; i++) f[i] = (i < frame.size()) ? frame[i] : 8'h00;
    case (f[0])
      8'hAA: begin
        a = f[1][3:0];
        expWr.push_back(int'({a, f[2]}));
        refMem[a] = f[2];
      end
      8'hBB: begin
        a = f[1][3:0];
        expRd.push_back(int'(a));
        expTx.push_back(int'(refMem[a]));
      end
      8'hCC, 8'hDD: begin
        if (f[0] == 8'hCC) begin
          expWr.push_back(int'({4'd0, f[1]}));
          expWr.push_back(int'({4'd1, f[2]}));
          refMem[0] = f[1];
          refMem[1] = f[2];
          a = f[3][3:0];
        end else begin
          a = f[1][3:0];
        end
        expAlu.push_back(int'(a));
        r = aluModel(refMem[0], refMem[1], a);
        expTx.push_back(int'(r[7:0]));
        expTx.push_back(int'(r[15:8]));
      end
      8'hEE: begin
        for (int k = 0; k < int'(f[2]); k++) begin
          a = 4'((int'(f[1]) + k) % 16);
          expRd.push_back(int'(a));
          expTx.push_back(int'(refMem[a]));
        end
      end
      default: expErr++;
    endcase
  endtask

  task automatic sendFrame();
    for (int i = 0; i < frame.size(); i++)
      applyStimulus(frame[i], (i == 0) ? $urandom_range(1, 3) : $urandom_range(0, 3));
  endtask

  task automatic waitDone();
    int n = 0;
    while (txQ.size() < expTx.size() && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    repeat (12) @(negedge CLK);
  endtask

  task automatic cmpQueue(input string tag, input int got[$], input int exp[$]);
    checkOutput({tag, ".count"}, got.size(), exp.size());
    for (int i = 0; i < got.size() && i < exp.size(); i++)
      checkOutput({tag, ".item"}, got[i], exp[i]);
  endtask

  task automatic compareAll(input string tag);
    cmpQueue({tag, ".wr"},  wrQ,  expWr);
    cmpQueue({tag, ".rd"},  rdQ,  expRd);
    cmpQueue({tag, ".alu"}, aluQ, expAlu);
    cmpQueue({tag, ".tx"},  txQ,  expTx);
    checkOutput({tag, ".frameErr"}, errCnt, expErr);
    checkOutput({tag, ".clkEnIdle"}, {31'd0, CLK_EN}, 32'd0);
  endtask

  task automatic runFrame(input string tag);
    clearAll();
    modelFrame();
    sendFrame();
    waitDone();
    compareAll(tag);
  endtask

  task automatic makeRandomFrame();
    int sel = $urandom_range(0, 5);
    logic [7:0] op;
    frame.delete();
    case (sel)
      0: begin frame.push_back(8'hAA); frame.push_back(8'($urandom)); frame.push_back(8'($urandom)); end
      1: begin frame.push_back(8'hBB); frame.push_back(8'($urandom)); end
      2: begin
        frame.push_back(8'hCC); frame.push_back(8'($urandom));
        frame.push_back(8'($urandom)); frame.push_back(8'($urandom_range(0, 5)));
      end
      3: begin frame.push_back(8'hDD); frame.push_back(8'($urandom_range(0, 5))); end
      4: begin frame.push_back(8'hEE); frame.push_back(8'($urandom)); frame.push_back(8'($urandom_range(0, 5))); end
      default: begin
        do op = 8'($urandom);
        while (op inside {8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE});
        frame.push_back(op);
      end
    endcase
  endtask

  // Watchdog so the run always ends even if the design wedges.
  initial begin
    #800000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    RST = 1'b1;
    RX_P_DATA = '0; RX_D_VLD = 1'b0;
    RD_DATA = '0; RD_DATA_VALID = 1'b0;
    ALU_OUT = '0; ALU_OUT_VALID = 1'b0;
    FIFO_FULL = 1'b0;
    for (int i = 0; i < 16; i++) begin
      rfMem[i]  = 8'($urandom);
      refMem[i] = rfMem[i];
    end
    repeat (3) @(negedge CLK);
    checkOutput("rst.ADDRESS",   32'(ADDRESS),   0);
    checkOutput("rst.WR_EN",     32'(WR_EN),     0);
    checkOutput("rst.RD_EN",     32'(RD_EN),     0);
    checkOutput("rst.WR_DATA",   32'(WR_DATA),   0);
    checkOutput("rst.ALU_EN",    32'(ALU_EN),    0);
    checkOutput("rst.ALU_FUN",   32'(ALU_FUN),   0);
    checkOutput("rst.CLK_EN",    32'(CLK_EN),    0);
    checkOutput("rst.TX_P_DATA", 32'(TX_P_DATA), 0);
    checkOutput("rst.TX_D_VLD",  32'(TX_D_VLD),  0);
    checkOutput("rst.FRAME_ERR", 32'(FRAME_ERR), 0);
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    frame = {8'hAA, 8'h05, 8'h3C};          runFrame("wr");
    frame = {8'hBB, 8'h05};                 runFrame("rd");
    frame = {8'hCC, 8'h0A, 8'h03, 8'h00};   runFrame("aluAdd");
    checkOutput("aluAdd.lsb", (txQ.size() > 0) ? txQ[0] : 32'hFFFF, 32'h0D);

    // Burst across the address wrap with the FIFO stalled and a stray RX byte.
    clearAll();
    frame = {8'hEE, 8'h0E, 8'h03};
    modelFrame();
    sendFrame();
    forceFull = 1'b1;
    repeat (5) @(negedge CLK);
    applyStimulus(8'h77, 0);
    repeat (15) @(negedge CLK);
    checkOutput("burst.heldNoPush", txQ.size(), 0);
    forceFull = 1'b0;
    waitDone();
    compareAll("burstWrap");

    frame = {8'hEE, 8'h03, 8'h00};          runFrame("burstZero");
    frame = {8'h77};                        runFrame("badOp");

    // Partial write frame left to time out.
    clearAll();
    applyStimulus(8'hAA, 1);
    applyStimulus(8'h05, 0);
    n = 0;
    while (errCnt == 0 && n < 3 * TO) begin
      @(negedge CLK);
      n++;
    end
    checkOutput("timeout.errCount", errCnt, 1);
    checkOutput("timeout.window", {31'd0, (n >= TO - 2 && n <= TO + 4)}, 1);
    repeat (5) @(negedge CLK);
    checkOutput("timeout.noWrite", wrQ.size(), 0);
    frame = {8'hBB, 8'h05};                 runFrame("afterTimeout");

    // Slow frame that stays just inside the timeout.
    clearAll();
    frame = {8'hAA, 8'h06, 8'h55};
    modelFrame();
    applyStimulus(8'hAA, 1);
    applyStimulus(8'h06, 0);
    applyStimulus(8'h55, TO - 2);
    waitDone();
    compareAll("slowWr");

    // Reset while the ALU result is outstanding.
    clearAll();
    aluSlow = 1'b1;
    frame = {8'hDD, 8'h02};
    sendFrame();
    n = 0;
    while (aluQ.size() == 0 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    checkOutput("rstMid.aluStarted", aluQ.size(), 1);
    repeat (3) @(negedge CLK);
    #1 RST = 1'b1;
    #1;
    checkOutput("rstMid.CLK_EN",   32'(CLK_EN),   0);
    checkOutput("rstMid.ALU_EN",   32'(ALU_EN),   0);
    checkOutput("rstMid.TX_D_VLD", 32'(TX_D_VLD), 0);
    aluDelay = 0;
    rdDelay  = 0;
    aluSlow  = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    frame = {8'hCC, 8'h21, 8'h07, 8'h02};   runFrame("afterReset");

    for (int t = 0; t < 60; t++) begin
      makeRandomFrame();
      runFrame("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
